// File: rtl/registro_universal_if.sv
// Bundle of the data and control signals of registro_universal.
// The block has no ready/valid pair. START is a request that the register
// takes only when it is idle and ENB is high, and only for shift modes.
// BUSY is high while the burst shifts, and DONE pulses once when it
// finishes. The driver watches BUSY/DONE and does not wait on a ready.
interface registro_universal_if #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int CNT_W = 6
);
    logic             enb;
    logic [2:0]       modo;
    logic             dir;
    logic [STEP-1:0]  s_in;
    logic [WIDTH-1:0] d;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q;
    logic [STEP-1:0]  s_out;
    logic             busy;
    logic             done;
    logic [1:0]       state_dbg;

    modport master (
        output enb, modo, dir, s_in, d, start, count,
        input  q, s_out, busy, done, state_dbg
    );

    modport slave (
        input  enb, modo, dir, s_in, d, start, count,
        output q, s_out, busy, done, state_dbg
    );
endinterface

// File: rtl/registro_universal.sv
// Universal shift register with hold/load/push/cycle/arith modes.
// Runs in continuous mode (the op is applied every enabled cycle) or in a
// counted burst mode driven by a small IDLE/RUN/FIN controller.
module registro_universal #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int CNT_W = 6
) (
    input logic               clk_i,
    input logic               rst_i,
    registro_universal_if.slave bus
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_PUSH  = 3'b010;
    localparam logic [2:0] MODE_CYCLE = 3'b011;
    localparam logic [2:0] MODE_ARITH = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             eff_dir;

    // One shift step. LOAD is handled by the caller, so it maps to "keep" here.
    function automatic logic [WIDTH-1:0] shift_op(
        input logic [2:0]       op,
        input logic             dr,
        input logic [WIDTH-1:0] v,
        input logic [STEP-1:0]  sin
    );
        logic [WIDTH-1:0] r;
        r = v;
        case (op)
            MODE_PUSH:  r = dr ? {sin, v[WIDTH-1:STEP]}
                               : {v[WIDTH-1-STEP:0], sin};
            MODE_CYCLE: r = dr ? {v[STEP-1:0], v[WIDTH-1:STEP]}
                               : {v[WIDTH-1-STEP:0], v[WIDTH-1 -: STEP]};
            MODE_ARITH: r = dr ? {{STEP{v[WIDTH-1]}}, v[WIDTH-1:STEP]}
                               : {v[WIDTH-1-STEP:0], {STEP{1'b0}}};
            default:    r = v;
        endcase
        return r;
    endfunction

    // Next-state, next-data and status decode for the burst controller.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.enb) begin
                    if (bus.start && (bus.modo inside {MODE_PUSH, MODE_CYCLE, MODE_ARITH})) begin
                        // Accept the burst: latch mode and direction, leave Q untouched.
                        mode_d  = bus.modo;
                        dir_d   = bus.dir;
                        cnt_d   = bus.count;
                        state_d = (bus.count != '0) ? ST_RUN : ST_FIN;
                    end else if (bus.modo == MODE_LOAD) begin
                        q_d = bus.d;
                    end else begin
                        q_d = shift_op(bus.modo, bus.dir, q_q, bus.s_in);
                    end
                end
            end
            ST_RUN: begin
                if (bus.enb) begin
                    q_d   = shift_op(mode_q, dir_q, q_q, bus.s_in);
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_FIN);
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Serial output follows the latched direction during a burst, the live one otherwise.
    always_comb begin
        eff_dir   = (state_q == ST_IDLE) ? bus.dir : dir_q;
        bus.s_out = eff_dir ? q_q[STEP-1:0] : q_q[WIDTH-1 -: STEP];
    end

    assign bus.q         = q_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;

endmodule
